// File: rtl/unpatchifier_pkg.sv
// unpatchifier_pkg: image/patch geometry, pixel width and FSM state shared with the patchifier.
package unpatchifier_pkg;
    localparam int DEF_CHANNEL_SIZE    = 8;
    localparam int DEF_NUM_CHANNELS    = 3;
    localparam int DEF_PIXEL_WIDTH     = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int DEF_IMG_WIDTH       = 16;
    localparam int DEF_IMG_HEIGHT      = 16;
    localparam int DEF_PATCH_SIZE      = 4;
    localparam int DEF_PATCH_SIZE_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/unpatch_addr_map.sv
// unpatch_addr_map: maps a patch-major input index to its raster row and column.
module unpatch_addr_map
    import unpatchifier_pkg::*;
#(
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE      = DEF_PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2 = DEF_PATCH_SIZE_LOG2,
    parameter int CNT_W           = clog2_min1(IMG_WIDTH * IMG_HEIGHT),
    parameter int ROW_W           = clog2_min1(IMG_HEIGHT),
    parameter int COL_W           = clog2_min1(IMG_WIDTH)
) (
    input  logic [CNT_W-1:0] k,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);
    localparam int PIR = IMG_WIDTH / PATCH_SIZE;
    localparam int PL2 = 2 * PATCH_SIZE_LOG2;

    logic [CNT_W-1:0] p, q;

    // p: patch number, q: position inside the patch
    assign p   = k >> PL2;
    assign q   = k & CNT_W'((1 << PL2) - 1);
    assign row = ROW_W'(((p / CNT_W'(PIR)) << PATCH_SIZE_LOG2) + (q >> PATCH_SIZE_LOG2));
    assign col = COL_W'(((p % CNT_W'(PIR)) << PATCH_SIZE_LOG2) + (q & CNT_W'(PATCH_SIZE - 1)));
endmodule

// File: rtl/unpatchifier.sv
// unpatchifier: buffers one patch-major frame, then streams it out in raster order.
module unpatchifier
    import unpatchifier_pkg::*;
#(
    parameter int CHANNEL_SIZE    = DEF_CHANNEL_SIZE,
    parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE      = DEF_PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2 = DEF_PATCH_SIZE_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_last,
    output logic                   done,
    output logic [1:0]             state
);
    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = clog2_min1(N);
    localparam int ROW_W = clog2_min1(IMG_HEIGHT);
    localparam int COL_W = clog2_min1(IMG_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t                 cur;
    logic [CNT_W-1:0]       in_cnt, out_cnt, waddr;
    logic [ROW_W-1:0]       row;
    logic [COL_W-1:0]       col;
    logic [PIXEL_WIDTH-1:0] mem [N];
    logic                   in_hs, out_hs;

    unpatch_addr_map #(
        .IMG_WIDTH      (IMG_WIDTH),
        .IMG_HEIGHT     (IMG_HEIGHT),
        .PATCH_SIZE     (PATCH_SIZE),
        .PATCH_SIZE_LOG2(PATCH_SIZE_LOG2),
        .CNT_W          (CNT_W),
        .ROW_W          (ROW_W),
        .COL_W          (COL_W)
    ) u_map (
        .k  (in_cnt),
        .row(row),
        .col(col)
    );

    assign state     = cur;
    assign in_ready  = (cur == LOAD);
    assign out_valid = (cur == DRAIN);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign waddr     = CNT_W'(row) * CNT_W'(IMG_WIDTH) + CNT_W'(col);
    assign out_pixel = mem[out_cnt];
    assign out_last  = out_valid && (out_cnt == LAST);

    // The buffer is deliberately not reset; a reset frame is simply abandoned.
    always_ff @(posedge clk)
        if (in_hs) mem[waddr] <= in_pixel;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur)
                IDLE: if (en) begin
                    cur    <= LOAD;
                    in_cnt <= '0;
                end
                LOAD: if (in_hs) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == LAST) begin
                        cur     <= DRAIN;
                        out_cnt <= '0;
                    end
                end
                DRAIN: if (out_hs) begin
                    out_cnt <= out_cnt + 1'b1;
                    if (out_cnt == LAST) begin
                        cur  <= IDLE;
                        done <= 1'b1;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end
endmodule
